timer_counter: RTL



---
 rtl/timer_counter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a
// maskable interrupt. Bus writes always take priority over FSM updates
// in the same cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | halted; COUNT holds; waits for Enable
// S_LOAD | COUNT is loaded from PRESET on the next edge
// S_CNT  | counting down; leaves on !Enable or on expiry
// S_INT  | expiry seen; periodic drops the flag, other modes stop
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       MODE_PER = 2'b01;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == 2'd0);
    assign preset_wr = we && (addr == 2'd1);

    // State and register updates; everything clears on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            if (preset_wr) begin
                preset_q <= wdata[CNT_W-1:0];
            end
        end
    end

    // Next-state and datapath; a CTRL write overrides whatever the FSM chose.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        flag_d  = flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == MODE_PER) begin
                    flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            ctrl_d = wdata[3:0];
            flag_d = 1'b0;
        end
    end

    // Read mux; unmapped offset reads zero.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, ctrl_q};
            2'd1:    rdata = 32'(preset_q);
            2'd2:    rdata = 32'(count_q);
            default: rdata = 32'd0;
        endcase
    end

    assign irq = ctrl_q[3] & flag_q;

endmodule
